// File: rtl/cache_pkg.sv
// Shared cache constants and fill-FSM state encoding.
// Also used by the I/D caches for block geometry.
package cache_pkg;

    localparam int ADDR_W      = 16;
    localparam int DATA_W      = 16;
    localparam int BLOCK_WORDS = 8;
    localparam int WORD_BYTES  = DATA_W / 8;
    localparam int OFFSET_W    = $clog2(BLOCK_WORDS * WORD_BYTES);
    localparam int CNT_W       = $clog2(BLOCK_WORDS) + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_TAG  = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        FILL = ST_FILL,
        TAG  = ST_TAG
    } fill_state_e;

endpackage

// File: rtl/fill_counter.sv
// Up counter with enable, synchronous clear and terminal-count flag.
// Used for the request and response word indices of a block fill.
module fill_counter #(
    parameter int W    = 4,
    parameter int TERM = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         done_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign done_o = (cnt_q == W'(TERM));

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss handler: reads a whole block from memory word by word,
// streams it into the data array, then writes the tag once.
module cache_fill_fsm
    import cache_pkg::*;
#(
    parameter int ADDR_W      = cache_pkg::ADDR_W,
    parameter int DATA_W      = cache_pkg::DATA_W,
    parameter int BLOCK_WORDS = cache_pkg::BLOCK_WORDS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic [DATA_W-1:0] memory_data,
    input  logic              memory_data_vld,
    output logic              fsm_busy,
    output logic              mem_en,
    output logic [ADDR_W-1:0] memory_address,
    output logic              write_data_array,
    output logic              write_tag_array,
    output logic [ADDR_W-1:0] cache_address,
    output logic [DATA_W-1:0] cache_data
);

    localparam int CW    = $clog2(BLOCK_WORDS) + 1;
    localparam int OFF_W = $clog2(BLOCK_WORDS * (DATA_W / 8));

    fill_state_e       state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;

    logic [CW-1:0] issue_cnt, recv_cnt;
    logic          issue_done, recv_done;
    logic          issue_en, recv_en, cnt_clr;

    assign cnt_clr = (state_q != FILL);

    fill_counter #(.W(CW), .TERM(BLOCK_WORDS)) u_issue_cnt (
        .clk    (clk),
        .rst_n  (rst),
        .clr_i  (cnt_clr),
        .en_i   (issue_en),
        .cnt_o  (issue_cnt),
        .done_o (issue_done)
    );

    fill_counter #(.W(CW), .TERM(BLOCK_WORDS)) u_recv_cnt (
        .clk    (clk),
        .rst_n  (rst),
        .clr_i  (cnt_clr),
        .en_i   (recv_en),
        .cnt_o  (recv_cnt),
        .done_o (recv_done)
    );

    always_comb begin
        state_d          = state_q;
        base_d           = base_q;
        fsm_busy         = 1'b0;
        mem_en           = 1'b0;
        memory_address   = '0;
        write_data_array = 1'b0;
        write_tag_array  = 1'b0;
        cache_address    = '0;
        cache_data       = '0;
        issue_en         = 1'b0;
        recv_en          = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Tag lookup path; forced to 0 while reset is held.
                cache_address = rst ? miss_address : '0;
                if (miss_detected) begin
                    base_d  = {miss_address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    state_d = FILL;
                end
            end
            FILL: begin
                fsm_busy      = 1'b1;
                cache_address = base_q;
                if (!issue_done) begin
                    mem_en         = 1'b1;
                    memory_address = base_q + ADDR_W'({issue_cnt, 1'b0});
                    issue_en       = 1'b1;
                end
                if (memory_data_vld && !recv_done) begin
                    write_data_array = 1'b1;
                    cache_address    = base_q + ADDR_W'({recv_cnt, 1'b0});
                    cache_data       = memory_data;
                    recv_en          = 1'b1;
                    if (recv_cnt == CW'(BLOCK_WORDS - 1)) begin
                        state_d = TAG;
                    end
                end
            end
            TAG: begin
                fsm_busy        = 1'b1;
                write_tag_array = 1'b1;
                cache_address   = base_q;
                state_d         = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
        end
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm: fills, address edge, spurious miss,
// mid-fill reset, gapped returns and back-to-back misses.
module tb_cache_fill_fsm;

    logic        clk;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic [15:0] memory_data;
    logic        memory_data_vld;
    logic        fsm_busy;
    logic        mem_en;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic        write_tag_array;
    logic [15:0] cache_address;
    logic [15:0] cache_data;

    int total = 0;
    int bad   = 0;

    cache_fill_fsm dut (
        .clk              (clk),
        .rst              (rst),
        .miss_detected    (miss_detected),
        .miss_address     (miss_address),
        .memory_data      (memory_data),
        .memory_data_vld  (memory_data_vld),
        .fsm_busy         (fsm_busy),
        .mem_en           (mem_en),
        .memory_address   (memory_address),
        .write_data_array (write_data_array),
        .write_tag_array  (write_tag_array),
        .cache_address    (cache_address),
        .cache_data       (cache_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] dat(input logic [15:0] a);
        return a ^ 16'hA5C3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input logic [15:0] a);
        @(negedge clk);
        miss_detected   = 1'b0;
        miss_address    = a;
        memory_data_vld = 1'b0;
        #1;
        chk({tag, "_busy"}, fsm_busy, 1'b0);
        chk({tag, "_memen"}, mem_en, 1'b0);
        chk({tag, "_wda"}, write_data_array, 1'b0);
        chk({tag, "_wta"}, write_tag_array, 1'b0);
        chk({tag, "_caddr"}, cache_address, a);
    endtask

    // One complete fill; word k returns at FILL cycle lat + k*gap.
    task automatic fill_run(input string tag, input logic [15:0] miss,
                            input int lat, input int gap, input bit spur);
        logic [15:0] base;
        int          tagc;
        int          kk;
        bit          vld;
        base = {miss[15:4], 4'h0};
        tagc = lat + 7 * gap + 1;
        @(negedge clk);
        miss_detected   = 1'b1;
        miss_address    = miss;
        memory_data_vld = 1'b0;
        #1;
        chk({tag, "_idle_busy"}, fsm_busy, 1'b0);
        chk({tag, "_idle_caddr"}, cache_address, miss);
        for (int c = 0; c <= tagc; c++) begin
            @(negedge clk);
            miss_detected = spur && (c == 3);
            miss_address  = (spur && (c == 3)) ? 16'h4000 : miss;
            vld = 1'b0;
            kk  = 0;
            for (int k = 0; k < 8; k++) begin
                if (lat + k * gap == c) begin
                    vld = 1'b1;
                    kk  = k;
                end
            end
            memory_data_vld = vld;
            memory_data     = vld ? dat(base + 16'(2 * kk)) : 16'hDEAD;
            #1;
            chk({tag, "_busy"}, fsm_busy, 1'b1);
            chk({tag, "_memen"}, mem_en, (c < 8));
            if (c < 8)
                chk({tag, "_maddr"}, memory_address, base + 16'(2 * c));
            chk({tag, "_wda"}, write_data_array, vld);
            if (vld) begin
                chk({tag, "_waddr"}, cache_address, base + 16'(2 * kk));
                chk({tag, "_wdata"}, cache_data, dat(base + 16'(2 * kk)));
            end
            chk({tag, "_wta"}, write_tag_array, (c == tagc));
            if (c == tagc)
                chk({tag, "_taddr"}, cache_address, base);
        end
        memory_data_vld = 1'b0;
    endtask

    initial begin
        rst             = 1'b1;
        miss_detected   = 1'b0;
        miss_address    = 16'h1234;
        memory_data     = 16'h0;
        memory_data_vld = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("rst_busy", fsm_busy, 1'b0);
        chk("rst_memen", mem_en, 1'b0);
        chk("rst_maddr", memory_address, 16'h0);
        chk("rst_wda", write_data_array, 1'b0);
        chk("rst_wta", write_tag_array, 1'b0);
        chk("rst_caddr", cache_address, 16'h0);
        chk("rst_cdata", cache_data, 16'h0);
        @(negedge clk);
        rst = 1'b1;

        // 1: basic fill, L=4
        fill_run("t1", 16'h1234, 4, 1, 1'b0);
        chk_idle("t1_end", 16'h1234);

        // 2: top of address space, no wrap
        fill_run("t2", 16'hFFF8, 4, 1, 1'b0);
        chk_idle("t2_end", 16'hFFF8);

        // 3: spurious miss mid-fill ignored
        fill_run("t3", 16'h0A56, 3, 1, 1'b1);
        chk_idle("t3_end", 16'h0A56);

        // 4: reset after 3 received words, then late returns dropped
        @(negedge clk);
        miss_detected = 1'b1;
        miss_address  = 16'h2000;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            miss_detected   = 1'b0;
            memory_data_vld = (c >= 4);
            memory_data     = dat(16'h2000 + 16'(2 * (c - 4)));
        end
        @(negedge clk);
        memory_data_vld = 1'b0;
        #1;
        chk("t4_pre_busy", fsm_busy, 1'b1);
        rst = 1'b0;
        #1;
        chk("t4_rst_busy", fsm_busy, 1'b0);
        chk("t4_rst_memen", mem_en, 1'b0);
        chk("t4_rst_maddr", memory_address, 16'h0);
        chk("t4_rst_wda", write_data_array, 1'b0);
        chk("t4_rst_wta", write_tag_array, 1'b0);
        chk("t4_rst_caddr", cache_address, 16'h0);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            memory_data_vld = 1'b1;
            memory_data     = 16'hBEEF;
            #1;
            chk("t4_late_wda", write_data_array, 1'b0);
            chk("t4_late_busy", fsm_busy, 1'b0);
            chk("t4_late_memen", mem_en, 1'b0);
        end
        chk_idle("t4_end", 16'h2000);

        // 5: valid every other cycle
        fill_run("t5", 16'h3330, 4, 2, 1'b0);
        chk_idle("t5_end", 16'h3330);

        // 6: back-to-back misses
        fill_run("t6a", 16'h0010, 4, 1, 1'b0);
        fill_run("t6b", 16'h0020, 4, 1, 1'b0);
        chk_idle("t6_end", 16'h0020);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
